// File: rtl/memory_client.sv
// memory_client: burst requester sitting on one shared-memory arbiter channel.
// Bursts are split into grant tenures of at most HOLD_MAX words.
module memory_client #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int LEN_W    = 8,
    parameter int HOLD_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              request,
    input  logic              grant,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int TEN_W = $clog2(HOLD_MAX + 1);
    localparam logic [TEN_W-1:0] TEN_MAX = TEN_W'(HOLD_MAX);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_XFER   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;
    localparam logic [2:0] S_YIELD  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic              wr_mode_q, wr_mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [TEN_W-1:0]  ten_q, ten_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wr_ack_q, wr_ack_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              request_q, request_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              issue;

    // State names the phase visible on the outputs; strobes for the next
    // cycle are registered one edge ahead, so XFER is a cycle with a strobe.
    always_comb begin
        state_d     = state_q;
        wr_mode_d   = wr_mode_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        ten_d       = ten_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        request_d   = request_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wr_d    = 1'b0;
        mem_rd_d    = 1'b0;
        wr_ack_d    = 1'b0;
        rd_valid_d  = mem_rd_q;
        rd_data_d   = mem_rd_q ? mem_rdata : rd_data_q;
        issue       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    wr_mode_d = cmd_write;
                    addr_d    = cmd_addr;
                    rem_d     = cmd_len;
                    ten_d     = '0;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = S_REQ;
                        busy_d    = 1'b1;
                        request_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (grant) begin
                    issue   = 1'b1;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (rem_q == '0) begin
                    if (wr_mode_q) begin
                        state_d   = S_FINISH;
                        request_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (!grant || ten_q == TEN_MAX) begin
                    state_d   = S_YIELD;
                    request_d = 1'b0;
                end else begin
                    issue = 1'b1;
                end
            end
            S_DRAIN: begin
                state_d   = S_FINISH;
                request_d = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            S_YIELD: begin
                // Arbiter grant is registered, so it lags our request drop.
                if (!grant) begin
                    ten_d     = '0;
                    state_d   = S_REQ;
                    request_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue) begin
            mem_addr_d = addr_q;
            mem_wr_d   = wr_mode_q;
            mem_rd_d   = !wr_mode_q;
            wr_ack_d   = wr_mode_q;
            if (wr_mode_q) begin
                mem_wdata_d = wr_data;
            end
            addr_d = addr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
            ten_d  = ten_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_mode_q   <= 1'b0;
            addr_q      <= '0;
            rem_q       <= '0;
            ten_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ack_q    <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            request_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_mode_q   <= wr_mode_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            ten_q       <= ten_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_ack_q    <= wr_ack_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            request_q   <= request_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wr_q    <= mem_wr_d;
            mem_rd_q    <= mem_rd_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign wr_ack    = wr_ack_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign request   = request_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr    = mem_wr_q;
    assign mem_rd    = mem_rd_q;

endmodule

// File: tb/tb_memory_client.sv
// tb_memory_client: arbiter, RAM and write-producer models around memory_client.
// Expected bus accesses and read words are queued when a command is sent.
module tb_memory_client;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LW = 8;
    localparam int HM = 4;
    localparam logic [DW-1:0] RDX = 16'hA5C3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          busy, done, wr_ack, rd_valid, request, grant;
    logic          mem_wr, mem_rd;
    logic [DW-1:0] wr_data, rd_data, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    int n_checks = 0;
    int n_fail = 0;
    logic block = 1'b0;
    logic [DW-1:0] wbase = '0;
    int ack_cnt;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } acc_t;
    acc_t exp_acc[$];
    logic [DW-1:0] exp_rd[$];

    int t_grant, t_first, t_last, t_rdv, t_done;
    int n_strobe, n_ack, n_rdv, n_done, n_gaps, min_gap;
    logic busy1, req1, req_ever, busy_ever, req_at_done, busy_at_done;
    logic r_req, r_wr, r_busy;
    int ten_log[$];

    always #5 clk = ~clk;

    memory_client #(
        .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .HOLD_MAX(HM)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .busy(busy), .done(done),
        .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .request(request), .grant(grant),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_rdata(mem_rdata)
    );

    // Registered arbiter channel; block models a busy higher-priority channel.
    always @(posedge clk or negedge rst) begin
        if (!rst) grant <= 1'b0;
        else grant <= request && !block;
    end

    // Producer presents the word after the one being acknowledged.
    always @(posedge clk or negedge rst) begin
        if (!rst) ack_cnt <= 0;
        else if (cmd_valid && !busy) ack_cnt <= 0;
        else if (wr_ack) ack_cnt <= ack_cnt + 1;
    end
    assign wr_data = wbase + DW'(ack_cnt) + DW'(wr_ack);

    assign mem_rdata = mem_addr ^ RDX;

    always @(negedge clk) begin : mon
        acc_t e;
        logic [DW-1:0] r;
        if (rst && (mem_wr || mem_rd)) begin
            n_checks++;
            if (!request || !grant) begin
                n_fail++;
                $display("FAIL bus_owner: request=%0b grant=%0b, want 1 1",
                         request, grant);
            end
            n_checks++;
            if (exp_acc.size() == 0) begin
                n_fail++;
                $display("FAIL access_extra: wr=%0b addr=%h, none expected",
                         mem_wr, mem_addr);
            end else begin
                e = exp_acc.pop_front();
                if (mem_wr !== e.w || mem_rd !== !e.w || mem_addr !== e.a
                    || (e.w && mem_wdata !== e.d)) begin
                    n_fail++;
                    $display("FAIL access: wr=%0b addr=%h d=%h, want wr=%0b addr=%h d=%h",
                             mem_wr, mem_addr, mem_wdata, e.w, e.a, e.d);
                end
            end
        end
        if (rst && (wr_ack || mem_wr)) begin
            n_checks++;
            if (wr_ack !== mem_wr) begin
                n_fail++;
                $display("FAIL wr_ack_align: wr_ack=%0b mem_wr=%0b", wr_ack, mem_wr);
            end
        end
        if (rst && rd_valid) begin
            n_checks++;
            if (exp_rd.size() == 0) begin
                n_fail++;
                $display("FAIL rd_extra: rd_data=%h, none expected", rd_data);
            end else begin
                r = exp_rd.pop_front();
                if (rd_data !== r) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h want %h", rd_data, r);
                end
            end
        end
    end

    task automatic run_burst(input logic w, input logic [AW-1:0] a,
                             input logic [LW-1:0] n, input int hold,
                             input bit hp, input int poke,
                             input int rst_after, input int budget);
        acc_t e;
        logic [AW-1:0] ak;
        int run, gap, hp_left;
        bit rst_done;
        t_grant = -1; t_first = -1; t_last = -1; t_rdv = -1; t_done = -1;
        n_strobe = 0; n_ack = 0; n_rdv = 0; n_done = 0; n_gaps = 0;
        min_gap = 1000; busy1 = 0; req1 = 0; req_ever = 0; busy_ever = 0;
        req_at_done = 1'bx; busy_at_done = 1'bx;
        r_req = 1'bx; r_wr = 1'bx; r_busy = 1'bx;
        ten_log.delete();
        run = 0; gap = 0; hp_left = 0; rst_done = 0;
        for (int k = 0; k < int'(n); k++) begin
            ak = a + AW'(k);
            e.w = w; e.a = ak; e.d = wbase + DW'(k);
            exp_acc.push_back(e);
            if (!w) exp_rd.push_back(ak ^ RDX);
        end
        @(negedge clk);
        cmd_write = w; cmd_addr = a; cmd_len = n; cmd_valid = 1'b1;
        block = (hold > 0);
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (rst_done && !rst) rst = 1'b1;
            if (i == 1) begin busy1 = busy; req1 = request; end
            if (grant && t_grant < 0) t_grant = i;
            if (mem_wr || mem_rd) begin
                if (t_first < 0) t_first = i;
                t_last = i; n_strobe++; run++;
            end else if (run > 0) begin
                ten_log.push_back(run); run = 0;
            end
            if (wr_ack) n_ack++;
            if (rd_valid) begin n_rdv++; t_rdv = i; end
            if (request) req_ever = 1;
            if (busy) busy_ever = 1;
            if (busy && !request) gap++;
            else if (request && gap > 0) begin
                n_gaps++;
                if (gap < min_gap) min_gap = gap;
                gap = 0;
            end
            if (done) begin
                n_done++;
                if (t_done < 0) begin
                    t_done = i; req_at_done = request; busy_at_done = busy;
                end
            end
            if (hp_left > 0) hp_left--;
            else if (hp && busy && !request) hp_left = 3;
            block = (i < hold) || (hp_left > 0);
            if (i == poke) begin
                cmd_write = 1'b1; cmd_addr = 16'h7777; cmd_len = 8'd5;
                cmd_valid = 1'b1;
            end
            if (rst_after > 0 && n_strobe == rst_after && !rst_done) begin
                #2 rst = 1'b0;
                #1 r_req = request; r_wr = mem_wr; r_busy = busy;
                rst_done = 1;
            end
            if (t_done >= 0 && i >= t_done + 2) break;
        end
        if (run > 0) ten_log.push_back(run);
        block = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, request, mem_wr, mem_rd, wr_ack, rd_valid} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {busy, done, request, mem_wr, mem_rd, wr_ack, rd_valid});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, rd_data} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, rd_data});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, request, done} !== 3'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b want 000", {busy, request, done});
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic test_write;
        wbase = 16'h5A00;
        run_burst(1'b1, 16'h0010, 8'd4, 0, 0, 4, 0, 30);
        n_checks++;
        if (t_done < 0) begin n_fail++; $display("FAIL wr_timeout: no done"); end
        n_checks++;
        if ({busy1, req1} !== 2'b11) begin
            n_fail++; $display("FAIL wr_cycle1: busy,req=%b want 11", {busy1, req1});
        end
        n_checks++;
        if (t_grant !== 2) begin n_fail++; $display("FAIL wr_grant: %0d want 2", t_grant); end
        n_checks++;
        if (t_first !== 3) begin n_fail++; $display("FAIL wr_first: %0d want 3", t_first); end
        n_checks++;
        if (t_last !== 6) begin n_fail++; $display("FAIL wr_last: %0d want 6", t_last); end
        n_checks++;
        if (n_ack !== 4) begin n_fail++; $display("FAIL wr_acks: %0d want 4", n_ack); end
        n_checks++;
        if (t_done !== 7) begin n_fail++; $display("FAIL wr_done: %0d want 7", t_done); end
        n_checks++;
        if ({req_at_done, busy_at_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL wr_done_req: req,busy=%b want 00", {req_at_done, busy_at_done});
        end
        n_checks++;
        if (n_done !== 1) begin n_fail++; $display("FAIL wr_ndone: %0d want 1", n_done); end
        n_checks++;
        if (exp_acc.size() !== 0) begin
            n_fail++; $display("FAIL wr_missing: %0d left want 0", exp_acc.size());
        end
    endtask

    task automatic test_read;
        run_burst(1'b0, 16'h0100, 8'd3, 5, 0, 0, 0, 40);
        n_checks++;
        if (t_grant !== 6) begin n_fail++; $display("FAIL rd_grant: %0d want 6", t_grant); end
        n_checks++;
        if (t_first !== 7) begin n_fail++; $display("FAIL rd_first: %0d want 7", t_first); end
        n_checks++;
        if (n_strobe !== 3) begin n_fail++; $display("FAIL rd_count: %0d want 3", n_strobe); end
        n_checks++;
        if (t_rdv !== 10) begin n_fail++; $display("FAIL rd_lastvalid: %0d want 10", t_rdv); end
        n_checks++;
        if (t_done !== 11) begin n_fail++; $display("FAIL rd_done: %0d want 11", t_done); end
        n_checks++;
        if (req_at_done !== 1'b0) begin
            n_fail++; $display("FAIL rd_done_req: %b want 0", req_at_done);
        end
        n_checks++;
        if (exp_rd.size() !== 0 || exp_acc.size() !== 0) begin
            n_fail++;
            $display("FAIL rd_missing: %0d/%0d left want 0", exp_acc.size(), exp_rd.size());
        end
    endtask

    task automatic test_yield;
        wbase = 16'h3300;
        run_burst(1'b1, 16'h0200, 8'd10, 0, 1, 0, 0, 80);
        n_checks++;
        if (ten_log.size() !== 3) begin
            n_fail++; $display("FAIL y_tenures: %0d want 3", ten_log.size());
        end else begin
            n_checks++;
            if (ten_log[0] !== 4 || ten_log[1] !== 4 || ten_log[2] !== 2) begin
                n_fail++;
                $display("FAIL y_lengths: %0d %0d %0d want 4 4 2",
                         ten_log[0], ten_log[1], ten_log[2]);
            end
        end
        n_checks++;
        if (n_gaps !== 2 || min_gap < 1) begin
            n_fail++; $display("FAIL y_gaps: n=%0d min=%0d want 2 >=1", n_gaps, min_gap);
        end
        n_checks++;
        if (n_ack !== 10) begin n_fail++; $display("FAIL y_acks: %0d want 10", n_ack); end
        n_checks++;
        if (t_done < 0 || t_done !== t_last + 1) begin
            n_fail++; $display("FAIL y_done: %0d want %0d", t_done, t_last + 1);
        end
        n_checks++;
        if (exp_acc.size() !== 0) begin
            n_fail++; $display("FAIL y_missing: %0d left want 0", exp_acc.size());
        end
    endtask

    task automatic test_len0;
        run_burst(1'b1, 16'h0040, 8'd0, 0, 0, 0, 0, 8);
        n_checks++;
        if (t_done !== 1) begin n_fail++; $display("FAIL z_done: %0d want 1", t_done); end
        n_checks++;
        if ({req_ever, busy_ever} !== 2'b00) begin
            n_fail++; $display("FAIL z_quiet: req,busy=%b want 00", {req_ever, busy_ever});
        end
        n_checks++;
        if (n_done !== 1) begin n_fail++; $display("FAIL z_ndone: %0d want 1", n_done); end
    endtask

    task automatic test_wrap;
        run_burst(1'b0, 16'hFFFE, 8'd4, 0, 0, 0, 0, 30);
        n_checks++;
        if (n_strobe !== 4 || n_rdv !== 4) begin
            n_fail++; $display("FAIL wrap_count: %0d/%0d want 4/4", n_strobe, n_rdv);
        end
        n_checks++;
        if (t_done < 0 || t_done !== t_last + 2) begin
            n_fail++; $display("FAIL wrap_done: %0d want %0d", t_done, t_last + 2);
        end
        n_checks++;
        if (exp_rd.size() !== 0 || exp_acc.size() !== 0) begin
            n_fail++; $display("FAIL wrap_missing: %0d/%0d left", exp_acc.size(), exp_rd.size());
        end
    endtask

    task automatic test_reset_mid;
        wbase = 16'h7100;
        run_burst(1'b1, 16'h0300, 8'd6, 0, 0, 0, 2, 15);
        n_checks++;
        if ({r_req, r_wr, r_busy} !== 3'b000) begin
            n_fail++; $display("FAIL rst_drop: req,wr,busy=%b want 000", {r_req, r_wr, r_busy});
        end
        n_checks++;
        if (n_done !== 0) begin n_fail++; $display("FAIL rst_nodone: %0d want 0", n_done); end
        n_checks++;
        if (n_strobe !== 2) begin n_fail++; $display("FAIL rst_words: %0d want 2", n_strobe); end
        exp_acc.delete();
        wbase = 16'h0900;
        run_burst(1'b1, 16'h0400, 8'd3, 0, 0, 0, 0, 30);
        check_int("rst_next_first", t_first, 3);
        check_int("rst_next_done", t_done, 6);
        check_int("rst_next_acks", n_ack, 3);
        check_int("rst_next_left", exp_acc.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_write;
        test_read;
        test_yield;
        test_len0;
        test_wrap;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
